// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller slice.
//   - Register byte offsets on the peripheral bus (only bits [3:2] decode).
//   - Bit positions inside the STATUS and CONTROL registers.
//   - State type of the bus handshake FSM.
package uart_pkg;

  localparam logic [3:0] UART_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;
  localparam logic [3:0] UART_CTRL_OFS   = 4'h8;
  localparam logic [3:0] UART_BAUD_OFS   = 4'hC;

  localparam int ST_RX_EMPTY    = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_PARITY_ERR  = 3;
  localparam int ST_STOP_ERR    = 4;
  localparam int ST_TX_OVF      = 5;
  localparam int ST_CFG_PENDING = 6;

  localparam int CTRL_PARITY_EN   = 0;
  localparam int CTRL_DOUBLE_STOP = 1;
  localparam int CTRL_IE_RX       = 2;
  localparam int CTRL_IE_TX       = 3;
  localparam int CTRL_IE_ERR      = 4;

  // A DATA read that finds the RX queue empty returns this marker.
  localparam logic [31:0] DATA_EMPTY_MARKER = 32'h0000_0100;

  typedef enum logic [1:0] {
    B_IDLE,
    B_POP,
    B_RESP
  } bus_state_t;

endpackage

// File: rtl/uart_cfg_shadow.sv
// Frame configuration shadow for the UART.
// The bus writes parity / stop-bit / baud settings into shadow registers.
// The settings go to the active outputs only once both serial engines are
// idle, so that a frame in flight never sees its format change.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ctrl_we, baud_we             CONTROL / BAUD register write strobes
//   wr_parity_en, wr_double_stop_bit, wr_baud_div   values being written
//   rx_busy, tx_busy             serial engine activity
//   shadow_*                     last written values (read back by the bus)
//   parity_en, double_stop_bit, baud_div           active configuration
//   cfg_pending                  shadow holds values not yet applied
module uart_cfg_shadow
  import uart_pkg::*;
#(
  parameter int BAUD_DIV_W     = 16,
  parameter int BAUD_DIV_RESET = 54
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_we,
  input  logic                  baud_we,
  input  logic                  wr_parity_en,
  input  logic                  wr_double_stop_bit,
  input  logic [BAUD_DIV_W-1:0] wr_baud_div,
  input  logic                  rx_busy,
  input  logic                  tx_busy,
  output logic                  shadow_parity_en,
  output logic                  shadow_double_stop_bit,
  output logic [BAUD_DIV_W-1:0] shadow_baud_div,
  output logic                  parity_en,
  output logic                  double_stop_bit,
  output logic [BAUD_DIV_W-1:0] baud_div,
  output logic                  cfg_pending
);

  // A fresh write always wins over an apply in the same cycle: the newest
  // shadow value is then applied at the next idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_parity_en       <= 1'b0;
      shadow_double_stop_bit <= 1'b0;
      shadow_baud_div        <= BAUD_DIV_W'(BAUD_DIV_RESET);
      parity_en              <= 1'b0;
      double_stop_bit        <= 1'b0;
      baud_div               <= BAUD_DIV_W'(BAUD_DIV_RESET);
      cfg_pending            <= 1'b0;
    end else begin
      if (ctrl_we) begin
        shadow_parity_en       <= wr_parity_en;
        shadow_double_stop_bit <= wr_double_stop_bit;
      end
      if (baud_we) begin
        shadow_baud_div <= wr_baud_div;
      end
      if (ctrl_we || baud_we) begin
        cfg_pending <= 1'b1;
      end else if (cfg_pending && !rx_busy && !tx_busy) begin
        parity_en       <= shadow_parity_en;
        double_stop_bit <= shadow_double_stop_bit;
        baud_div        <= shadow_baud_div;
        cfg_pending     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped register front end of the UART.
// Pushes bytes into the TX queue, pops bytes from the RX queue, keeps
// sticky RX/TX error flags, and feeds the frame configuration to the
// serial engines through an idle-gated shadow.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   bus_addr/re/we/wdata             CPU bus request (held until bus_ready)
//   bus_rdata, bus_ready             read data and one-cycle completion
//   tx_queue_we/din/full/empty       TX queue push side and status
//   rx_queue_re/dout/empty           RX queue pop side (dout is the head)
//   parity_error_if, stop_bit_error_if  error pulses from the RX engine
//   rx_busy, tx_busy                 serial engine activity
//   parity_en, double_stop_bit, baud_div  active frame configuration
//   irq                              registered level interrupt
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV_W     = 16,
  parameter int BAUD_DIV_RESET = 54
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            bus_addr,
  input  logic                  bus_re,
  input  logic                  bus_we,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  bus_ready,
  output logic                  tx_queue_we,
  output logic [7:0]            tx_queue_din,
  input  logic                  tx_queue_full,
  input  logic                  tx_queue_empty,
  output logic                  rx_queue_re,
  input  logic [7:0]            rx_queue_dout,
  input  logic                  rx_queue_empty,
  input  logic                  parity_error_if,
  input  logic                  stop_bit_error_if,
  input  logic                  rx_busy,
  input  logic                  tx_busy,
  output logic                  parity_en,
  output logic                  double_stop_bit,
  output logic [BAUD_DIV_W-1:0] baud_div,
  output logic                  irq
);

  localparam logic [1:0] SEL_DATA   = UART_DATA_OFS[3:2];
  localparam logic [1:0] SEL_STATUS = UART_STATUS_OFS[3:2];
  localparam logic [1:0] SEL_CTRL   = UART_CTRL_OFS[3:2];

  bus_state_t state, state_next;

  logic [1:0]  sel;
  logic        req;
  logic        do_access;
  logic        start_pop;
  logic        capture_pop;
  logic        ready_next;
  logic        data_we, status_we, ctrl_we, baud_we;
  logic [31:0] rd_value;
  logic [6:0]  status;
  logic [4:0]  ctrl;

  logic parity_err, stop_err, tx_ovf;
  logic ie_rx, ie_tx, ie_err;

  logic                  shadow_parity_en, shadow_double_stop_bit, cfg_pending;
  logic [BAUD_DIV_W-1:0] shadow_baud_div;

  // Address bits [1:0] and the upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  uart_cfg_shadow #(
    .BAUD_DIV_W     (BAUD_DIV_W),
    .BAUD_DIV_RESET (BAUD_DIV_RESET)
  ) u_cfg_shadow (
    .clk                    (clk),
    .reset                  (reset),
    .ctrl_we                (ctrl_we),
    .baud_we                (baud_we),
    .wr_parity_en           (bus_wdata[CTRL_PARITY_EN]),
    .wr_double_stop_bit     (bus_wdata[CTRL_DOUBLE_STOP]),
    .wr_baud_div            (bus_wdata[BAUD_DIV_W-1:0]),
    .rx_busy                (rx_busy),
    .tx_busy                (tx_busy),
    .shadow_parity_en       (shadow_parity_en),
    .shadow_double_stop_bit (shadow_double_stop_bit),
    .shadow_baud_div        (shadow_baud_div),
    .parity_en              (parity_en),
    .double_stop_bit        (double_stop_bit),
    .baud_div               (baud_div),
    .cfg_pending            (cfg_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= B_IDLE;
    else       state <= state_next;
  end

  // Request decode and next state. While bus_ready is high the master is
  // still holding the finished request, so it must not be taken again.
  // A simultaneous read and write is handled as a write.
  always_comb begin
    state_next  = state;
    sel         = bus_addr[3:2];
    req         = (bus_re || bus_we) && !bus_ready;
    do_access   = 1'b0;
    start_pop   = 1'b0;
    capture_pop = 1'b0;
    ready_next  = 1'b0;
    case (state)
      B_IDLE: begin
        if (req) begin
          if (!bus_we && sel == SEL_DATA && !rx_queue_empty) begin
            start_pop  = 1'b1;
            state_next = B_POP;
          end else begin
            do_access  = 1'b1;
            state_next = B_RESP;
          end
        end
      end
      B_POP: begin
        capture_pop = 1'b1;
        state_next  = B_RESP;
      end
      B_RESP: begin
        ready_next = 1'b1;
        state_next = B_IDLE;
      end
      default: state_next = B_IDLE;
    endcase
    data_we   = do_access && bus_we && sel == SEL_DATA;
    status_we = do_access && bus_we && sel == SEL_STATUS;
    ctrl_we   = do_access && bus_we && sel == SEL_CTRL;
    baud_we   = do_access && bus_we && sel == UART_BAUD_OFS[3:2];
  end

  // Read mux. A DATA read only reaches here when the RX queue is empty.
  always_comb begin
    status                 = '0;
    status[ST_RX_EMPTY]    = rx_queue_empty;
    status[ST_TX_FULL]     = tx_queue_full;
    status[ST_TX_EMPTY]    = tx_queue_empty;
    status[ST_PARITY_ERR]  = parity_err;
    status[ST_STOP_ERR]    = stop_err;
    status[ST_TX_OVF]      = tx_ovf;
    status[ST_CFG_PENDING] = cfg_pending;
    ctrl                   = '0;
    ctrl[CTRL_PARITY_EN]   = shadow_parity_en;
    ctrl[CTRL_DOUBLE_STOP] = shadow_double_stop_bit;
    ctrl[CTRL_IE_RX]       = ie_rx;
    ctrl[CTRL_IE_TX]       = ie_tx;
    ctrl[CTRL_IE_ERR]      = ie_err;
    case (sel)
      SEL_DATA:   rd_value = DATA_EMPTY_MARKER;
      SEL_STATUS: rd_value = {25'b0, status};
      SEL_CTRL:   rd_value = {27'b0, ctrl};
      default:    rd_value = {{(32-BAUD_DIV_W){1'b0}}, shadow_baud_div};
    endcase
  end

  // Datapath: strobes, read data, sticky flags, enables and interrupt.
  // Sticky flags: a new error pulse beats a write-1-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ready    <= 1'b0;
      bus_rdata    <= '0;
      tx_queue_we  <= 1'b0;
      tx_queue_din <= '0;
      rx_queue_re  <= 1'b0;
      parity_err   <= 1'b0;
      stop_err     <= 1'b0;
      tx_ovf       <= 1'b0;
      ie_rx        <= 1'b0;
      ie_tx        <= 1'b0;
      ie_err       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      bus_ready   <= ready_next;
      rx_queue_re <= start_pop;
      tx_queue_we <= data_we && !tx_queue_full;
      if (data_we && !tx_queue_full) begin
        tx_queue_din <= bus_wdata[7:0];
      end
      if (do_access) begin
        bus_rdata <= bus_we ? 32'h0 : rd_value;
      end else if (capture_pop) begin
        bus_rdata <= {24'b0, rx_queue_dout};
      end
      parity_err <= parity_error_if ||
                    (parity_err && !(status_we && bus_wdata[ST_PARITY_ERR]));
      stop_err   <= stop_bit_error_if ||
                    (stop_err && !(status_we && bus_wdata[ST_STOP_ERR]));
      tx_ovf     <= (data_we && tx_queue_full) ||
                    (tx_ovf && !(status_we && bus_wdata[ST_TX_OVF]));
      if (ctrl_we) begin
        ie_rx  <= bus_wdata[CTRL_IE_RX];
        ie_tx  <= bus_wdata[CTRL_IE_TX];
        ie_err <= bus_wdata[CTRL_IE_ERR];
      end
      irq <= (ie_rx && !rx_queue_empty) || (ie_tx && tx_queue_empty) ||
             (ie_err && (parity_err || stop_err || tx_ovf));
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl: directed register-map scenarios
// followed by randomized accesses, all compared against a register-level
// reference model kept here. The bench also plays the TX/RX queues.
module tb_uart_bus_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bus_addr;
  logic        bus_re, bus_we;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic        tx_queue_we;
  logic [7:0]  tx_queue_din;
  logic        tx_queue_full, tx_queue_empty;
  logic        rx_queue_re;
  logic [7:0]  rx_queue_dout;
  logic        rx_queue_empty;
  logic        parity_error_if, stop_bit_error_if;
  logic        rx_busy, tx_busy;
  logic        parity_en, double_stop_bit;
  logic [15:0] baud_div;
  logic        irq;

  always #5 clk = ~clk;

  uart_bus_ctrl #(.BAUD_DIV_W(16), .BAUD_DIV_RESET(54)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus_addr          (bus_addr),
    .bus_re            (bus_re),
    .bus_we            (bus_we),
    .bus_wdata         (bus_wdata),
    .bus_rdata         (bus_rdata),
    .bus_ready         (bus_ready),
    .tx_queue_we       (tx_queue_we),
    .tx_queue_din      (tx_queue_din),
    .tx_queue_full     (tx_queue_full),
    .tx_queue_empty    (tx_queue_empty),
    .rx_queue_re       (rx_queue_re),
    .rx_queue_dout     (rx_queue_dout),
    .rx_queue_empty    (rx_queue_empty),
    .parity_error_if   (parity_error_if),
    .stop_bit_error_if (stop_bit_error_if),
    .rx_busy           (rx_busy),
    .tx_busy           (tx_busy),
    .parity_en         (parity_en),
    .double_stop_bit   (double_stop_bit),
    .baud_div          (baud_div),
    .irq               (irq)
  );

  int checks = 0;
  int failures = 0;

  // RX queue contents (head at index 0) and observed strobes.
  logic [7:0] rx_model[$];
  logic       pop_pending;
  int         tx_pulses, pop_pulses;
  logic [7:0] tx_byte;

  // Reference model of the register file.
  logic        m_ie_rx, m_ie_tx, m_ie_err;
  logic        m_pe, m_se, m_ovf, m_pending;
  logic        m_sh_parity, m_sh_dstop, m_act_parity, m_act_dstop;
  logic [15:0] m_sh_baud, m_act_baud;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic syncRxQueue();
    rx_queue_empty = (rx_model.size() == 0);
    rx_queue_dout  = (rx_model.size() != 0) ? rx_model[0] : 8'h00;
  endtask

  // One clock; observe strobes 1 time unit after the edge. A pop seen now
  // takes effect on the queue at the following edge (dout is the head).
  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pending) begin
      if (rx_model.size() != 0) rx_model.delete(0);
      syncRxQueue();
    end
    pop_pending = rx_queue_re;
    if (rx_queue_re) pop_pulses++;
    if (tx_queue_we) begin
      tx_pulses++;
      tx_byte = tx_queue_din;
    end
  endtask

  task automatic modelReset();
    m_ie_rx = 0; m_ie_tx = 0; m_ie_err = 0;
    m_pe = 0; m_se = 0; m_ovf = 0; m_pending = 0;
    m_sh_parity = 0; m_sh_dstop = 0; m_act_parity = 0; m_act_dstop = 0;
    m_sh_baud = 16'd54; m_act_baud = 16'd54;
  endtask

  task automatic modelSettle();
    if (m_pending && !rx_busy && !tx_busy) begin
      m_act_parity = m_sh_parity;
      m_act_dstop  = m_sh_dstop;
      m_act_baud   = m_sh_baud;
      m_pending    = 0;
    end
  endtask

  function automatic logic modelIrq();
    return (m_ie_rx && rx_model.size() != 0) || (m_ie_tx && tx_queue_empty) ||
           (m_ie_err && (m_pe || m_se || m_ovf));
  endfunction

  task automatic pulseErr(input logic pe, input logic se);
    parity_error_if   = pe;
    stop_bit_error_if = se;
    tick();
    parity_error_if   = 0;
    stop_bit_error_if = 0;
    if (pe) m_pe = 1;
    if (se) m_se = 1;
  endtask

  task automatic checkStatic(input string name);
    checkOutput($sformatf("%s_baud_div", name), 32'(baud_div), 32'(m_act_baud));
    checkOutput($sformatf("%s_parity_en", name), 32'(parity_en), 32'(m_act_parity));
    checkOutput($sformatf("%s_dstop", name), 32'(double_stop_bit), 32'(m_act_dstop));
    checkOutput($sformatf("%s_irq", name), 32'(irq), 32'(modelIrq()));
  endtask

  // One bus access; pe_pulse raises parity_error_if in the request cycle.
  task automatic applyStimulus(input string name, input logic [3:0] addr, input logic re,
                               input logic we, input logic [31:0] wdata, input logic pe_pulse);
    logic [31:0] exp_rdata;
    int          exp_lat, exp_tx, exp_pop, lat;
    logic        got_ready;
    exp_rdata = 32'h0; exp_lat = 2; exp_tx = 0; exp_pop = 0;
    if (!we) begin
      case (addr[3:2])
        2'd0: if (rx_model.size() != 0) begin
                exp_rdata = {24'h0, rx_model[0]}; exp_lat = 3; exp_pop = 1;
              end else exp_rdata = 32'h0000_0100;
        2'd1: exp_rdata = {25'h0, m_pending, m_ovf, m_se, m_pe, tx_queue_empty,
                           tx_queue_full, rx_model.size() == 0};
        2'd2: exp_rdata = {27'h0, m_ie_err, m_ie_tx, m_ie_rx, m_sh_dstop, m_sh_parity};
        default: exp_rdata = {16'h0, m_sh_baud};
      endcase
    end else begin
      case (addr[3:2])
        2'd0: if (tx_queue_full) m_ovf = 1; else exp_tx = 1;
        2'd1: begin
                if (wdata[3]) m_pe = 0;
                if (wdata[4]) m_se = 0;
                if (wdata[5]) m_ovf = 0;
              end
        2'd2: begin
                m_ie_rx = wdata[2]; m_ie_tx = wdata[3]; m_ie_err = wdata[4];
                m_sh_parity = wdata[0]; m_sh_dstop = wdata[1]; m_pending = 1;
              end
        default: begin m_sh_baud = wdata[15:0]; m_pending = 1; end
      endcase
    end
    if (pe_pulse) m_pe = 1;
    tx_pulses = 0; pop_pulses = 0;
    bus_addr = addr; bus_re = re; bus_we = we; bus_wdata = wdata;
    parity_error_if = pe_pulse;
    lat = 0; got_ready = 0;
    while (!got_ready && lat < 8) begin
      tick();
      lat++;
      parity_error_if = 0;
      got_ready = bus_ready;
    end
    bus_re = 0; bus_we = 0;
    checkOutput($sformatf("%s_ready_seen", name), 32'(got_ready), 32'd1);
    if (got_ready) begin
      checkOutput($sformatf("%s_latency", name), 32'(lat), 32'(exp_lat));
      if (!we) checkOutput($sformatf("%s_rdata", name), bus_rdata, exp_rdata);
    end
    tick();
    checkOutput($sformatf("%s_ready_pulse", name), 32'(bus_ready), 32'd0);
    checkOutput($sformatf("%s_tx_pulses", name), 32'(tx_pulses), 32'(exp_tx));
    if (exp_tx == 1 && tx_pulses == 1)
      checkOutput($sformatf("%s_tx_byte", name), 32'(tx_byte), {24'h0, wdata[7:0]});
    checkOutput($sformatf("%s_pops", name), 32'(pop_pulses), 32'(exp_pop));
    modelSettle();
  endtask

  initial begin
    logic [3:0]  addr;
    logic        re, we;
    logic [31:0] wdata;
    reset = 1; bus_addr = 0; bus_re = 0; bus_we = 0; bus_wdata = 0;
    tx_queue_full = 0; tx_queue_empty = 1;
    parity_error_if = 0; stop_bit_error_if = 0; rx_busy = 0; tx_busy = 0;
    pop_pending = 0; tx_pulses = 0; pop_pulses = 0; tx_byte = 0;
    rx_model.delete();
    syncRxQueue();
    modelReset();
    tick(); tick(); tick();
    reset = 0;
    tick();

    // Reset state
    checkOutput("rst_bus_ready", 32'(bus_ready), 32'd0);
    checkOutput("rst_bus_rdata", bus_rdata, 32'd0);
    checkOutput("rst_tx_we", 32'(tx_queue_we), 32'd0);
    checkOutput("rst_rx_re", 32'(rx_queue_re), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_baud_div", 32'(baud_div), 32'd54);
    applyStimulus("rst_rd_baud", UART_BAUD_OFS, 1, 0, 0, 0);
    applyStimulus("rst_rd_ctrl", UART_CTRL_OFS, 1, 0, 0, 0);

    // TX push, RX pop, RX read when empty
    applyStimulus("wr_data", UART_DATA_OFS, 0, 1, 32'h1A5, 0);
    rx_model.push_back(8'h3C);
    syncRxQueue();
    applyStimulus("rd_data_pop", UART_DATA_OFS, 1, 0, 0, 0);
    applyStimulus("rd_data_empty", UART_DATA_OFS, 1, 0, 0, 0);

    // Configuration deferred while the receiver is busy
    rx_busy = 1;
    applyStimulus("wr_baud_busy", UART_BAUD_OFS, 0, 1, 32'd27, 0);
    checkOutput("baud_held", 32'(baud_div), 32'd54);
    applyStimulus("rd_status_pend", UART_STATUS_OFS, 1, 0, 0, 0);
    rx_busy = 0;
    tick();
    modelSettle();
    checkOutput("baud_applied", 32'(baud_div), 32'd27);
    applyStimulus("rd_status_done", UART_STATUS_OFS, 1, 0, 0, 0);

    // Sticky parity error, set-beats-clear, then clean clear
    applyStimulus("wr_ctrl_ie_err", UART_CTRL_OFS, 0, 1, 32'h10, 0);
    pulseErr(1, 0);
    tick();
    checkOutput("irq_on_parity", 32'(irq), 32'd1);
    applyStimulus("w1c_vs_pulse", UART_STATUS_OFS, 0, 1, 32'h08, 1);
    applyStimulus("rd_status_pe", UART_STATUS_OFS, 1, 0, 0, 0);
    applyStimulus("w1c_clean", UART_STATUS_OFS, 0, 1, 32'h08, 0);
    tick();
    checkOutput("irq_cleared", 32'(irq), 32'd0);
    checkStatic("dir");

    // TX overflow
    tx_queue_full = 1; tx_queue_empty = 0;
    applyStimulus("wr_data_full", UART_DATA_OFS, 0, 1, 32'h55, 0);
    applyStimulus("rd_status_ovf", UART_STATUS_OFS, 1, 0, 0, 0);
    checkStatic("ovf");

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      rx_busy = ($urandom_range(0, 3) == 0);
      tx_busy = ($urandom_range(0, 3) == 0);
      tx_queue_full = ($urandom_range(0, 3) == 0);
      tx_queue_empty = tx_queue_full ? 1'b0 : 1'($urandom_range(0, 1));
      if (rx_model.size() < 4 && $urandom_range(0, 1) == 1) begin
        rx_model.push_back(8'($urandom));
        syncRxQueue();
      end
      if ($urandom_range(0, 4) == 0)
        pulseErr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(); tick();
      modelSettle();
      addr  = 4'($urandom_range(0, 15));
      we    = 1'($urandom_range(0, 1));
      re    = we ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata = $urandom;
      applyStimulus("rnd", addr, re, we, wdata, 1'b0);
      checkStatic("rnd");
    end

    // Reset in the middle of an access
    rx_busy = 0; tx_busy = 0; tx_queue_full = 0; tx_queue_empty = 1;
    bus_addr = UART_DATA_OFS; bus_we = 1; bus_re = 0; bus_wdata = 32'h77;
    tick();
    reset = 1;
    tick();
    checkOutput("midrst_ready_a", 32'(bus_ready), 32'd0);
    checkOutput("midrst_tx_we_a", 32'(tx_queue_we), 32'd0);
    bus_we = 0;
    reset = 0;
    tick();
    checkOutput("midrst_ready_b", 32'(bus_ready), 32'd0);
    checkOutput("midrst_tx_we_b", 32'(tx_queue_we), 32'd0);
    checkOutput("midrst_rx_re_b", 32'(rx_queue_re), 32'd0);
    tick();
    checkOutput("midrst_ready_c", 32'(bus_ready), 32'd0);
    modelReset();
    pop_pending = 0;
    checkStatic("midrst");
    applyStimulus("post_rst_baud", UART_BAUD_OFS, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
Memory-mapped register front end that configures and sequences the UART from the CPU data bus. It pushes bytes into the TX queue and pops bytes from the RX queue. It captures RX error pulses as sticky flags and drives the frame configuration (parity, stop bits, baud divisor) into the RX/TX controllers. Configuration changes are applied only when both serial engines are idle. It sits between the core's peripheral bus decoder and the UART RX/TX controllers and queues.

Parameters:
BAUD_DIV_W, 16, width of baud divisor register
BAUD_DIV_RESET, 54, divisor loaded at reset (100 MHz, 115200 baud, 16x oversampling)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
bus_addr  in  4  byte address; bits [1:0] ignored
bus_re  in  1  read request; held until bus_ready
bus_we  in  1  write request; held until bus_ready
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid when bus_ready
bus_ready  out  1  one-cycle access completion
tx_queue_we  out  1  push bus_wdata[7:0] into TX queue
tx_queue_din  out  8  TX byte
tx_queue_full  in  1  TX queue full
tx_queue_empty  in  1  TX queue empty
rx_queue_re  out  1  pop RX queue; data valid next cycle
rx_queue_dout  in  8  RX queue head
rx_queue_empty  in  1  RX queue empty
parity_error_if  in  1  one-cycle parity error pulse from RX controller
stop_bit_error_if  in  1  one-cycle stop-bit error pulse from RX controller
rx_busy  in  1  RX controller not idle
tx_busy  in  1  TX controller not idle
parity_en  out  1  active parity enable
double_stop_bit  out  1  active two-stop-bit mode
baud_div  out  BAUD_DIV_W  active baud divisor
irq  out  1  level interrupt, registered

Behaviour:
- Register map:
  - 0x0 DATA: write pushes byte; read pops byte.
  - 0x4 STATUS: bit0 rx_empty, 1 tx_full, 2 tx_empty, 3 parity_err, 4 stop_err, 5 tx_ovf, 6 cfg_pending. Bits 3-5 are sticky, write-1-to-clear.
  - 0x8 CONTROL: bit0 parity_en, bit1 double_stop_bit, bit2 ie_rx, bit3 ie_tx, bit4 ie_err.
  - 0xC BAUD: [BAUD_DIV_W-1:0].
  - Unmapped bits read 0.
- Reset values:
  - bus_ready=0, bus_rdata=0, tx_queue_we=0, rx_queue_re=0, irq=0.
  - parity_en=0, double_stop_bit=0, baud_div=BAUD_DIV_RESET.
  - Sticky flags, interrupt enables and cfg_pending all 0.
- Bus FSM states: B_IDLE, B_POP, B_RESP.
  - B_IDLE, request present:
    - DATA read with !rx_queue_empty: assert rx_queue_re for 1 cycle, go to B_POP.
    - Any other access: perform it, go to B_RESP.
  - B_POP: capture {24'b0, rx_queue_dout} into bus_rdata, go to B_RESP.
  - B_RESP: bus_ready=1 for one cycle, go to B_IDLE. A new request is sampled no earlier than the cycle after bus_ready.
  - Latency: 2 cycles for register access and DATA write; 3 cycles for DATA read with a pop.
  - bus_re and bus_we both high: treated as a write.
- DATA read with rx_queue_empty: no pop; returns 0x0000_0100 (bit8 = empty marker).
- DATA write:
  - !tx_queue_full: tx_queue_we=1 for exactly one cycle with tx_queue_din=bus_wdata[7:0].
  - tx_queue_full: byte dropped, tx_ovf set. Access still completes.
- Sticky flags:
  - Set on the corresponding input pulse, or on TX overflow for tx_ovf.
  - Set and W1C in the same cycle: set wins.
- Configuration shadow:
  - CONTROL/BAUD writes update the interrupt enables immediately.
  - parity_en, double_stop_bit and baud_div go to a shadow register and set cfg_pending.
  - The shadow is applied in the first cycle with !rx_busy && !tx_busy, which clears cfg_pending.
  - A second write while pending overwrites the shadow; only the latest value is applied.
  - Reads of CONTROL/BAUD return the shadow (last written) value.
- irq registered each cycle: (ie_rx & !rx_queue_empty) | (ie_tx & tx_queue_empty) | (ie_err & (parity_err|stop_err|tx_ovf)).
- Reset mid-access: FSM returns to B_IDLE; no strobe or bus_ready is emitted in the reset cycle or the cycle after.

Decomposition:
- Shared package uart_pkg:
  - register offset constants: UART_DATA_OFS, UART_STATUS_OFS, UART_CTRL_OFS, UART_BAUD_OFS.
  - STATUS/CONTROL bit-index constants.
  - bus FSM enum type.
- One natural sub-module: uart_cfg_shadow (shadow registers plus the idle-gated apply logic and cfg_pending).
- The rest is a flat FSM with datapath.

Test Plan:
- Reset, then read BAUD and CONTROL -> 54 and 0x0; irq=0; baud_div=54.
- Write DATA 0x1A5 with TX not full -> single tx_queue_we pulse, tx_queue_din=0xA5, bus_ready 2 cycles after request.
- RX queue holds 0x3C, read DATA -> rx_queue_re one pulse, bus_rdata=0x0000_003C on bus_ready at cycle 3. Read again with queue empty -> 0x0000_0100, no pop.
- Write BAUD=27 while rx_busy=1 -> baud_div stays 54, STATUS bit6=1. Drop rx_busy -> baud_div=27 next cycle, bit6=0.
- Pulse parity_error_if with ie_err=1 -> STATUS bit3=1, irq=1. Write STATUS 0x08 in the same cycle as another pulse -> bit3 stays 1. Clean W1C -> bit3=0, irq=0.
- Fill TX (tx_queue_full=1), write DATA -> no tx_queue_we, STATUS bit5=1.
